// File: rtl/arb_pkg.sv
// Shared types and helpers for the slave-FIFO arbiter: FSM state encoding,
// counter widths and the packet-length code decode.
package arb_pkg;

  localparam int PRIO_W = 2;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] pkglen_decode(input logic [1:0] code);
    case (code)
      2'd0:    return 6'd4;
      2'd1:    return 6'd8;
      2'd2:    return 6'd16;
      2'd3:    return 6'd32;
      default: return 6'd4;
    endcase
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select among requesting channels: highest priority wins.
// Ties rotate from the last grant when ARB_RR_EN is defined, else lowest index wins.
module arb_pick
  import arb_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0]        req,
  input  logic [PRIO_W*NUM_CH-1:0] prio,
`ifdef ARB_RR_EN
  input  logic [1:0]               last,
`endif
  output logic [1:0]               winner,
  output logic                     any_req
);

  int                start;
  int                rank;
  int                best_rank;
  logic [PRIO_W-1:0] best_p;
  logic              found;

  // Scan all channels; rank is the distance from the tie-break start point
  always_comb begin
    winner    = 2'd0;
    best_p    = '0;
    best_rank = NUM_CH;
    found     = 1'b0;
    rank      = 0;
`ifdef ARB_RR_EN
    start = (int'(last) + 1) % NUM_CH;
`else
    start = 0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      rank = (c >= start) ? (c - start) : (c + NUM_CH - start);
      if (req[c] && (!found || (prio[c*PRIO_W +: PRIO_W] > best_p) ||
                     ((prio[c*PRIO_W +: PRIO_W] == best_p) && (rank < best_rank)))) begin
        found     = 1'b1;
        best_p    = prio[c*PRIO_W +: PRIO_W];
        best_rank = rank;
        winner    = 2'(c);
      end else begin
        found = found;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/slave_arbiter.sv
// Grants one slave FIFO per packet, acks it for up to one packet length and
// forwards returned words with id/sop/eop. Define ARB_RR_EN for round-robin ties.
module slave_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DW     = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NUM_CH-1:0]        slv_req_i,
  input  logic [NUM_CH-1:0]        slv_val_i,
  input  logic [NUM_CH*DW-1:0]     slv_data_i,
  input  logic [PRIO_W*NUM_CH-1:0] slv_prio_i,
  input  logic [1:0]               pkglen_i,
  input  logic                     f2a_ready_i,
  output logic [NUM_CH-1:0]        a2s_ack_o,
  output logic                     a2f_val_o,
  output logic [DW-1:0]            a2f_data_o,
  output logic [1:0]               a2f_id_o,
  output logic                     a2f_sop_o,
  output logic                     a2f_eop_o,
  output logic                     a2f_busy_o
);

  state_t           state;
  logic [1:0]       grant;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] rcv;
  logic [1:0]       winner;
  logic             any_req;
  logic             ack_now;
  logic             req_g;
  logic             val_g;
  logic             fwd;
  logic [DW-1:0]    data_g;
`ifdef ARB_RR_EN
  logic [1:0]       last_ptr;
`endif

  arb_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req     (slv_req_i),
    .prio    (slv_prio_i),
`ifdef ARB_RR_EN
    .last    (last_ptr),
`endif
    .winner  (winner),
    .any_req (any_req)
  );

  // Ack is combinational so it drops the instant reset or req goes away
  always_comb begin
    a2s_ack_o = '0;
    if ((state == BURST) && (issued < len)) begin
      a2s_ack_o[grant] = slv_req_i[grant];
    end else begin
      a2s_ack_o = '0;
    end
  end

  assign ack_now = |a2s_ack_o;
  assign req_g   = slv_req_i[grant];
  assign val_g   = slv_val_i[grant];
  assign data_g  = slv_data_i[grant*DW +: DW];
  assign fwd     = val_g && (state != IDLE);

  // FSM, counters and registered formatter outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      grant      <= 2'd0;
      len        <= 6'd0;
      issued     <= 6'd0;
      rcv        <= 6'd0;
      a2f_val_o  <= 1'b0;
      a2f_data_o <= '0;
      a2f_id_o   <= 2'd0;
      a2f_sop_o  <= 1'b0;
      a2f_eop_o  <= 1'b0;
      a2f_busy_o <= 1'b0;
`ifdef ARB_RR_EN
      last_ptr   <= 2'(NUM_CH - 1);
`endif
    end else begin
      a2f_val_o  <= fwd;
      a2f_data_o <= data_g;
      a2f_id_o   <= grant;
      a2f_sop_o  <= fwd && (rcv == 6'd0);
      // A word with no ack alongside it is the reply to the final ack
      a2f_eop_o  <= fwd && !ack_now;
      if (fwd && (rcv < 6'd32)) begin
        rcv <= rcv + 6'd1;
      end else begin
        rcv <= rcv;
      end
      case (state)
        IDLE: begin
          if (any_req && f2a_ready_i) begin
            grant      <= winner;
            len        <= pkglen_decode(pkglen_i);
            issued     <= 6'd0;
            rcv        <= 6'd0;
            state      <= BURST;
            a2f_busy_o <= 1'b1;
`ifdef ARB_RR_EN
            last_ptr   <= winner;
`endif
          end else begin
            a2f_busy_o <= 1'b0;
          end
        end
        BURST: begin
          a2f_busy_o <= 1'b1;
          if (ack_now) begin
            issued <= issued + 6'd1;
          end else begin
            issued <= issued;
          end
          if ((ack_now && ((issued + 6'd1) == len)) || !req_g) begin
            state <= DRAIN;
          end else begin
            state <= BURST;
          end
        end
        DRAIN: begin
          state      <= IDLE;
          a2f_busy_o <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          a2f_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_arbiter.sv
// Randomized and directed bench for slave_arbiter with a packet-level reference
// model (grant windows, word lists) and emulated slave FIFOs.
module tb_slave_arbiter;

  localparam int NUM_CH = 3;
  localparam int DW     = 8;

  logic                 clk = 1'b0;
  logic                 rstn_i;
  logic [NUM_CH-1:0]    slv_req_i;
  logic [NUM_CH-1:0]    slv_val_i;
  logic [NUM_CH*DW-1:0] slv_data_i;
  logic [2*NUM_CH-1:0]  slv_prio_i;
  logic [1:0]           pkglen_i;
  logic                 f2a_ready_i;
  logic [NUM_CH-1:0]    a2s_ack_o;
  logic                 a2f_val_o;
  logic [DW-1:0]        a2f_data_o;
  logic [1:0]           a2f_id_o;
  logic                 a2f_sop_o;
  logic                 a2f_eop_o;
  logic                 a2f_busy_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [NUM_CH][256];
  int wr [NUM_CH];
  int rd [NUM_CH];

  int   cyc, idle_from, pk_c, pk_n, pk_w, pk_len, m_ptr;
  bit   pk_valid;
  logic [7:0] pk_words [32];
  logic [NUM_CH-1:0] ack_s;
  int   nwords, first_val_cyc, rdy_cyc, n_ack;
  int   obs_ids [$];
  int   exp4 [4];

  always #5 clk = ~clk;

  slave_arbiter #(.NUM_CH(NUM_CH), .DW(DW)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .slv_req_i   (slv_req_i),
    .slv_val_i   (slv_val_i),
    .slv_data_i  (slv_data_i),
    .slv_prio_i  (slv_prio_i),
    .pkglen_i    (pkglen_i),
    .f2a_ready_i (f2a_ready_i),
    .a2s_ack_o   (a2s_ack_o),
    .a2f_val_o   (a2f_val_o),
    .a2f_data_o  (a2f_data_o),
    .a2f_id_o    (a2f_id_o),
    .a2f_sop_o   (a2f_sop_o),
    .a2f_eop_o   (a2f_eop_o),
    .a2f_busy_o  (a2f_busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lenof(input logic [1:0] code);
    return 4 << code;
  endfunction

  // Score = priority dominates, then closeness to the tie-break start point
  function automatic int model_pick();
    int best   = -1;
    int bscore = -1;
    int start  = 0;
    int score;
`ifdef ARB_RR_EN
    start = (m_ptr + 1) % NUM_CH;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (slv_req_i[c]) begin
        score = int'(slv_prio_i[2*c +: 2]) * NUM_CH + (NUM_CH - 1 - ((c - start + NUM_CH) % NUM_CH));
        if (score > bscore) begin
          bscore = score;
          best   = c;
        end
      end
    end
    return best;
  endfunction

  task automatic update_req();
    for (int c = 0; c < NUM_CH; c++) slv_req_i[c] = (wr[c] != rd[c]);
  endtask

  task automatic push(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      mem[c][wr[c] % 256] = 8'($urandom);
      wr[c]++;
    end
    update_req();
  endtask

  task automatic flush();
    for (int c = 0; c < NUM_CH; c++) rd[c] = wr[c];
    update_req();
  endtask

  // One clock: check at negedge against the model, then emulate slave FIFOs after posedge
  task automatic tick();
    logic [NUM_CH-1:0] exp_ack;
    logic exp_val;
    int   exp_i;
    @(negedge clk);
    cyc++;
    exp_ack = '0;
    if (pk_valid && (cyc >= pk_c + 1) && (cyc <= pk_c + pk_n)) exp_ack[pk_w] = 1'b1;
    chk("ack", 32'(a2s_ack_o), 32'(exp_ack));
    chk("busy", 32'(a2f_busy_o), 32'(pk_valid && (cyc >= pk_c + 1) && (cyc < idle_from)));
    exp_val = pk_valid && (cyc >= pk_c + 3) && (cyc <= pk_c + pk_n + 2);
    chk("val", 32'(a2f_val_o), 32'(exp_val));
    if (exp_val && a2f_val_o) begin
      exp_i = cyc - pk_c - 3;
      chk("data", 32'(a2f_data_o), 32'(pk_words[exp_i]));
      chk("sop", 32'(a2f_sop_o), 32'(exp_i == 0));
      chk("eop", 32'(a2f_eop_o), 32'(exp_i == pk_n - 1));
      chk("id", 32'(a2f_id_o), 32'(pk_w));
    end
    if (a2f_val_o) begin
      nwords++;
      if (first_val_cyc < 0) first_val_cyc = cyc;
      if (a2f_sop_o) obs_ids.push_back(int'(a2f_id_o));
    end
    if ((cyc >= idle_from) && (|slv_req_i) && f2a_ready_i) begin
      pk_w   = model_pick();
      pk_c   = cyc;
      pk_len = lenof(pkglen_i);
      pk_n   = wr[pk_w] - rd[pk_w];
      if (pk_n > pk_len) pk_n = pk_len;
      for (int i = 0; i < pk_n; i++) pk_words[i] = mem[pk_w][(rd[pk_w] + i) % 256];
      idle_from = cyc + pk_n + ((pk_n == pk_len) ? 2 : 3);
      pk_valid  = 1'b1;
      m_ptr     = pk_w;
    end
    ack_s = a2s_ack_o;
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ack_s[c] && (rd[c] != wr[c])) begin
        slv_val_i[c] = 1'b1;
        slv_data_i[c*DW +: DW] = mem[c][rd[c] % 256];
        rd[c]++;
      end else begin
        slv_val_i[c] = 1'b0;
        slv_data_i[c*DW +: DW] = 8'($urandom);
      end
    end
    update_req();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    #1;
    chk("rst_ack", 32'(a2s_ack_o), 32'h0);
    chk("rst_val", 32'(a2f_val_o), 32'h0);
    slv_val_i = '0;
    pk_valid  = 1'b0;
    idle_from = 0;
    m_ptr     = NUM_CH - 1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rstn_i = 1'b1;
  endtask

  initial begin
    rstn_i = 1'b0;
    slv_val_i = '0;
    slv_data_i = '0;
    slv_prio_i = '0;
    pkglen_i = 2'd0;
    f2a_ready_i = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr[c] = 0;
      rd[c] = 0;
    end
    update_req();
    cyc = 0; idle_from = 0; pk_valid = 1'b0; m_ptr = NUM_CH - 1;
    first_val_cyc = -1; nwords = 0; pk_c = 0; pk_n = 0; pk_w = 0; pk_len = 4;

    @(posedge clk);
    #1;
    chk("reset_ack", 32'(a2s_ack_o), 32'h0);
    chk("reset_val", 32'(a2f_val_o), 32'h0);
    chk("reset_busy", 32'(a2f_busy_o), 32'h0);
    chk("reset_sop_eop", 32'({a2f_sop_o, a2f_eop_o}), 32'h0);
    chk("reset_id_data", 32'({a2f_id_o, a2f_data_o}), 32'h0);
    @(posedge clk);
    #1;
    rstn_i = 1'b1;

    // T1: ch0 holds 10 words, 4-word packet; ready drops mid-packet
    push(0, 10);
    pkglen_i = 2'd0;
    f2a_ready_i = 1'b1;
    nwords = 0;
    obs_ids.delete();
    run(2);
    f2a_ready_i = 1'b0;
    run(12);
    chk("t1_words", 32'(nwords), 32'd4);
    chk("t1_left", 32'(wr[0] - rd[0]), 32'd6);
    chk("t1_pkts", 32'(obs_ids.size()), 32'd1);
    flush();

    // T2: short packet, ch1 holds 3 words with an 8-word length
    nwords = 0;
    pkglen_i = 2'd1;
    push(1, 3);
    f2a_ready_i = 1'b1;
    run(12);
    chk("t2_words", 32'(nwords), 32'd3);
    chk("t2_left", 32'(wr[1] - rd[1]), 32'd0);

    // T3: ch2 at priority 3 beats ch0 at priority 1
    f2a_ready_i = 1'b0;
    slv_prio_i = 6'b11_00_01;
    pkglen_i = 2'd0;
    push(0, 4);
    push(2, 4);
    obs_ids.delete();
    f2a_ready_i = 1'b1;
    run(25);
    chk("t3_pkts", 32'(obs_ids.size()), 32'd2);
    if (obs_ids.size() == 2) begin
      chk("t3_first", 32'(obs_ids[0]), 32'd2);
      chk("t3_second", 32'(obs_ids[1]), 32'd0);
    end

    // T4: equal priorities, all channels full, from a fresh reset
    do_reset();
    slv_prio_i = 6'b10_10_10;
    push(0, 40);
    push(1, 40);
    push(2, 40);
    obs_ids.delete();
    for (int k = 0; (k < 80) && (obs_ids.size() < 4); k++) tick();
    f2a_ready_i = 1'b0;
    run(10);
`ifdef ARB_RR_EN
    exp4 = '{0, 1, 2, 0};
`else
    exp4 = '{0, 0, 0, 0};
`endif
    chk("t4_pkts", 32'(obs_ids.size()), 32'd4);
    for (int i = 0; (i < 4) && (i < obs_ids.size()); i++) chk("t4_order", 32'(obs_ids[i]), 32'(exp4[i]));
    flush();

    // T5: back-pressure, then a 32-word packet
    pkglen_i = 2'd3;
    push(1, 40);
    run(5);
    first_val_cyc = -1;
    nwords = 0;
    f2a_ready_i = 1'b1;
    rdy_cyc = cyc + 1;
    run(12);
    f2a_ready_i = 1'b0;
    run(40);
    chk("t5_latency", 32'(first_val_cyc - rdy_cyc), 32'd3);
    chk("t5_words", 32'(nwords), 32'd32);
    chk("t5_left", 32'(wr[1] - rd[1]), 32'd8);
    flush();

    // T6: reset during BURST after two acks
    pkglen_i = 2'd1;
    push(2, 10);
    f2a_ready_i = 1'b1;
    n_ack = 0;
    for (int k = 0; (k < 30) && (n_ack < 2); k++) begin
      tick();
      if (ack_s[2]) n_ack++;
    end
    chk("t6_two_acks", 32'(n_ack), 32'd2);
    #1;
    chk("t6_pre_ack", 32'(a2s_ack_o), 32'h4);
    chk("t6_pre_val", 32'(a2f_val_o), 32'h1);
    do_reset();
    obs_ids.delete();
    nwords = 0;
    run(20);
    chk("t6_restart_pkts", 32'(obs_ids.size()), 32'd1);
    if (obs_ids.size() > 0) chk("t6_restart_id", 32'(obs_ids[0]), 32'd2);
    chk("t6_restart_words", 32'(nwords), 32'd8);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      int c;
      f2a_ready_i = (($urandom % 4) != 0);
      pkglen_i = 2'($urandom);
      slv_prio_i = 6'($urandom);
      if (($urandom % 3) == 0) begin
        c = int'($urandom % NUM_CH);
        if (!(pk_valid && (c == pk_w) && (cyc + 1 < idle_from)) && ((wr[c] - rd[c]) < 60))
          push(c, 1 + int'($urandom % 6));
      end
      tick();
    end
    f2a_ready_i = 1'b0;
    run(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
